// File: rtl/mips_pkg.sv
// Shared MIPS memory-side definitions: access size codes, load/store FSM states
// and the alignment rule used when a request is accepted.
package mips_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_t;

  // Size 2'b11 has no legal encoding, so it is reported the same way as a bad address.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = a[0];
      SZ_WORD: is_misaligned = (a != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/subword_extract.sv
// Load-path lane select with sign/zero extension of a little-endian read word.
// Purely combinational so any load path can reuse it.
module subword_extract
  import mips_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data_out
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: data_out = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SZ_HALF: data_out = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default: data_out = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_subword_unit.sv
// MEM-stage to data-memory bridge: narrows store data into byte lanes, extends load data,
// and runs a one-outstanding request/ack handshake with misalignment and timeout reporting.
module load_store_subword_unit
  import mips_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_misalign,
  output logic              rsp_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT_CYC);

  lsu_state_t        state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_misalign_q, rsp_misalign_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [1:0]        a_lo_q, a_lo_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              accept, bad_align, timeout_hit;
  logic [31:0]       load_data;

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: store_be = 4'b0001 << a;
      SZ_HALF: store_be = a[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      SZ_BYTE: store_lanes = {4{wd[7:0]}};
      SZ_HALF: store_lanes = {2{wd[15:0]}};
      default: store_lanes = wd;
    endcase
  endfunction

  assign accept      = req_valid && req_ready_q && (state_q == ST_IDLE);
  assign bad_align   = is_misaligned(req_size, req_addr[1:0]);
  assign cnt_inc     = cnt_q + 1'b1;
  assign timeout_hit = !mem_ack && (cnt_inc == TO_CNT);

  subword_extract u_extract (
    .rdata       (mem_rdata),
    .addr_lo     (a_lo_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data_out    (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      req_ready_q    <= 1'b1;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_be_q       <= '0;
      mem_wdata_q    <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_misalign_q <= 1'b0;
      rsp_timeout_q  <= 1'b0;
      cnt_q          <= '0;
      a_lo_q         <= '0;
      size_q         <= '0;
      uns_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_ready_q    <= req_ready_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_be_q       <= mem_be_d;
      mem_wdata_q    <= mem_wdata_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_misalign_q <= rsp_misalign_d;
      rsp_timeout_q  <= rsp_timeout_d;
      cnt_q          <= cnt_d;
      a_lo_q         <= a_lo_d;
      size_q         <= size_d;
      uns_q          <= uns_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = bad_align ? ST_RESP : ST_ACCESS;
      ST_ACCESS: if (mem_ack || timeout_hit) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Response fields only change when a new response is produced, so they hold in between.
  always_comb begin
    req_ready_d    = req_ready_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_be_d       = mem_be_q;
    mem_wdata_d    = mem_wdata_q;
    rsp_valid_d    = 1'b0;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_misalign_d = rsp_misalign_q;
    rsp_timeout_d  = rsp_timeout_q;
    cnt_d          = cnt_q;
    a_lo_d         = a_lo_q;
    size_d         = size_q;
    uns_d          = uns_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_ready_d = 1'b0;
          a_lo_d      = req_addr[1:0];
          size_d      = req_size;
          uns_d       = req_unsigned;
          cnt_d       = '0;
          if (bad_align) begin
            rsp_valid_d    = 1'b1;
            rsp_rdata_d    = '0;
            rsp_misalign_d = 1'b1;
            rsp_timeout_d  = 1'b0;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_be_d    = req_we ? store_be(req_size, req_addr[1:0]) : 4'b1111;
            mem_wdata_d = store_lanes(req_size, req_wdata);
          end
        end
      end
      ST_ACCESS: begin
        if (mem_ack) begin
          mem_req_d      = 1'b0;
          mem_we_d       = 1'b0;
          rsp_valid_d    = 1'b1;
          rsp_rdata_d    = mem_we_q ? 32'd0 : load_data;
          rsp_misalign_d = 1'b0;
          rsp_timeout_d  = 1'b0;
        end else begin
          cnt_d = cnt_inc;
          if (timeout_hit) begin
            mem_req_d      = 1'b0;
            mem_we_d       = 1'b0;
            rsp_valid_d    = 1'b1;
            rsp_rdata_d    = '0;
            rsp_misalign_d = 1'b0;
            rsp_timeout_d  = 1'b1;
          end
        end
      end
      ST_RESP: req_ready_d = 1'b1;
      default: req_ready_d = 1'b1;
    endcase
  end

  assign req_ready    = req_ready_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_be       = mem_be_q;
  assign mem_wdata    = mem_wdata_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_misalign = rsp_misalign_q;
  assign rsp_timeout  = rsp_timeout_q;

endmodule
